qspi_cmd_tx: RTL and testbench
==============================

# qspi_cmd_tx

Quad-SPI command transmitter: the initiator end of the 4-bit host link that `spi_driver` receives. It serialises a byte stream (opcode, headers, vertices, triangles, transforms) into CS_n-framed nibble transfers on `sck`/`spi_io`. It is used for on-board loopback into the raster front-end and as the synthesizable stimulus source in system benches. Framing is one CS_n-low window per input packet, delimited by `s_last`.

## Interface
Parameters:
- `CLK_DIV`, 2: sck half-period in clk cycles; legal range 1..255.
- `CS_SETUP`, 2: clk cycles from CS_n fall to first sck rise; legal range 1..255.
- `CS_HOLD`, 2: clk cycles from last sck fall to CS_n rise; legal range 1..255.
- `GAP`, 4: minimum clk cycles with CS_n high between frames; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  byte to send.
- `s_valid`  in  1  `s_data`/`s_last` valid.
- `s_last`  in  1  byte is the final byte of the frame.
- `s_ready`  out  1  byte accepted when `s_valid && s_ready`.
- `sck`  out  1  SPI clock, idle low (mode 0).
- `CS_n`  out  1  chip select, active low.
- `spi_io_o`  out  4  nibble driven to the link.
- `spi_io_oe`  out  1  tristate enable for `spi_io_o`.
- `busy`  out  1  high whenever state is not IDLE.
- `frame_done`  out  1  one-cycle pulse on CS_n rise.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW, NEXT, HOLD, GAP. A nibble flag tracks hi/lo. A down-counter times each phase.
- Byte order on the wire: high nibble first. Bit 3 of the nibble maps to `spi_io[3]`.
- The receiver samples on sck rise. Data changes only while sck is low.
- IDLE: `s_ready`=1. On handshake:
  - latch byte and last flag;
  - set CS_n=0, `spi_io_oe`=1, `spi_io_o`=high nibble;
  - go to SETUP.
- SETUP: hold for CS_SETUP cycles with sck=0, then go to HIGH.
- HIGH: sck=1 for CLK_DIV cycles. Exit depends on the nibble just sent:
  - after the high nibble: go to LOW and drive the low nibble;
  - after the low nibble, last=0: go to NEXT;
  - after the low nibble, last=1: go to HOLD.
- LOW: sck=0 for CLK_DIV cycles, then go to HIGH.
- NEXT: sck=0, CS_n stays low, `s_ready`=1.
  - On handshake: latch byte, drive high nibble, go to LOW.
  - With no `s_valid`: stall indefinitely; sck stays low and CS_n stays low.
- HOLD: sck=0, data held for CS_HOLD cycles. Then set CS_n=1, `spi_io_oe`=0, `spi_io_o`=0, pulse `frame_done`, and go to GAP.
- GAP: `s_ready`=0 for GAP cycles, then go to IDLE.
- `s_ready` is 0 in every state not listed above.
- A single byte with `s_last`=1 is a legal one-byte frame. There is no zero-length frame.

## Timing
- Reset values: `sck`=0, `CS_n`=1, `spi_io_o`=0, `spi_io_oe`=0, `busy`=0, `frame_done`=0, `s_ready`=0 while `rst` is low. Reset enters IDLE.
- Reset mid-frame: outputs return to idle values immediately (asynchronously). The partial frame is dropped and no `frame_done` is issued.
- All outputs are registered except `s_ready`, which is decoded from the state register.
- First byte: CS_n low for CS_SETUP + 3·CLK_DIV cycles before the low nibble's HIGH phase ends.
- Streaming bytes: 4·CLK_DIV + 1 clk cycles per byte when `s_valid` is held high.
- One-byte frame with default parameters:
  - CS_n low for exactly 10 cycles (2 SETUP, 2 HIGH, 2 LOW, 2 HIGH, 2 HOLD);
  - next `s_ready` arrives 4 cycles after CS_n rises.
- Exactly two sck rising edges per byte. sck never toggles while CS_n is high.

## Configuration
- `QSPI_CMD_TX_CRC_EN` defined: after the last byte's low-nibble HIGH phase, the block sends one extra internally generated byte (LOW→HIGH→LOW→HIGH, `s_ready`=0), then goes to HOLD.
  - The extra byte is CRC-8 with poly 0x07, init 0x00, MSB-first, computed over all payload bytes of the frame.
  - The CRC is reset on every IDLE→SETUP transition.
- Undefined: no CRC logic; HOLD follows the last payload byte directly.

## Structure
- Package `qspi_tx_pkg`: state enum `qspi_tx_state_t`, `CRC8_POLY`=8'h07, `CRC8_INIT`=8'h00.
- Sub-module `crc8_step` (combinational, byte in + crc in → crc out). Instantiated only under `QSPI_CMD_TX_CRC_EN`.

## Test plan
- Single byte 0xA5 with `s_last`, default parameters: CS_n low 10 cycles; sampled nibbles 0xA then 0x5; `frame_done` pulses once; `s_ready` returns 4 cycles later.
- Stream 0x01,0x02,0x03 with `s_valid` always high (last on 0x03): one CS_n window; six sck rises sampling 0,1,0,2,0,3; byte period 9 cycles.
- Stream with a 20-cycle `s_valid` gap after byte 1: sck held low and CS_n held low through the stall; correct bytes received on resume.
- Assert `rst` low mid-byte: CS_n=1, sck=0, oe=0 immediately; no `frame_done`; next frame after release is transmitted cleanly.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, GAP=1 with back-to-back frames: sck period 2 cycles; at least 1 cycle CS_n high between frames.
- `QSPI_CMD_TX_CRC_EN`, frame 0x01,0x02: trailing byte 0x1B on the wire before CS_n rises.

Source files
------------

// File: rtl/qspi_tx_pkg.sv
// qspi_tx_pkg: shared definitions for the quad-SPI command transmitter.
//   qspi_tx_state_t : transmitter FSM state encoding
//   CRC8_POLY/INIT  : CRC-8 trailer parameters (poly 0x07, MSB-first)
//   crc8_byte()     : folds one byte into a running CRC-8
package qspi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } qspi_tx_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    function automatic logic [7:0] crc8_byte(input logic [7:0] data, input logic [7:0] crc_in);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/qspi_cmd_tx_crc8_step.sv
// crc8_step: combinational CRC-8 update, one byte per evaluation.
//   data    in  8  payload byte
//   crc_in  in  8  running CRC before this byte
//   crc_out out 8  running CRC after this byte
// Only present when QSPI_CMD_TX_CRC_EN is defined, the only build that uses it.
`ifdef QSPI_CMD_TX_CRC_EN
module crc8_step
    import qspi_tx_pkg::*;
(
    input  logic [7:0] data,
    input  logic [7:0] crc_in,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_byte(data, crc_in);

endmodule
`endif

// File: rtl/qspi_cmd_tx.sv
// qspi_cmd_tx: quad-SPI command transmitter (link initiator, SPI mode 0).
// Serialises a byte stream into CS_n-framed nibble transfers, high nibble
// first, one CS_n-low window per packet delimited by s_last.
//   clk, rst             clock / asynchronous active-low reset
//   s_data/valid/last    byte stream in; s_ready accepts (decoded from state)
//   sck, CS_n            SPI clock (idle low) and chip select (active low)
//   spi_io_o, spi_io_oe  nibble and its tristate enable
//   busy, frame_done     not-idle flag; one-cycle pulse on CS_n rise
// Build option: QSPI_CMD_TX_CRC_EN appends a CRC-8 byte to every frame.
module qspi_cmd_tx
    import qspi_tx_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       sck,
    output logic       CS_n,
    output logic [3:0] spi_io_o,
    output logic       spi_io_oe,
    output logic       busy,
    output logic       frame_done
);

    // Phase counters load N-1 and leave the phase when they read zero.
    localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP - 1);

    qspi_tx_state_t state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [7:0] byte_r, byte_s;
    logic       last_r, last_s;
    logic       nib_hi_r, nib_hi_s;
    logic       sck_r, sck_s;
    logic       cs_n_r, cs_n_s;
    logic [3:0] io_r, io_s;
    logic       oe_r, oe_s;
    logic       done_r, done_s;
    logic       busy_r, busy_s;

`ifdef QSPI_CMD_TX_CRC_EN
    logic [7:0] crc_r, crc_s, crc_seed_s, crc_next_s;
    logic       crc_sent_r, crc_sent_s;

    // A byte accepted from IDLE starts a new frame, so it seeds from init.
    assign crc_seed_s = (state_r == ST_IDLE) ? CRC8_INIT : crc_r;

    crc8_step u_crc8_step (
        .data    (s_data),
        .crc_in  (crc_seed_s),
        .crc_out (crc_next_s)
    );
`endif

    // s_ready is gated by rst so it reads 0 while reset is held.
    assign s_ready    = rst & ((state_r == ST_IDLE) | (state_r == ST_NEXT));
    assign sck        = sck_r;
    assign CS_n       = cs_n_r;
    assign spi_io_o   = io_r;
    assign spi_io_oe  = oe_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

    // Next-state and next-output decode for the framing FSM.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        byte_s   = byte_r;
        last_s   = last_r;
        nib_hi_s = nib_hi_r;
        sck_s    = sck_r;
        cs_n_s   = cs_n_r;
        io_s     = io_r;
        oe_s     = oe_r;
        done_s   = 1'b0;
`ifdef QSPI_CMD_TX_CRC_EN
        crc_s      = crc_r;
        crc_sent_s = crc_sent_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (s_valid) begin
                    byte_s   = s_data;
                    last_s   = s_last;
                    nib_hi_s = 1'b1;
                    cs_n_s   = 1'b0;
                    oe_s     = 1'b1;
                    io_s     = s_data[7:4];
                    cnt_s    = SETUP_LD;
                    state_s  = ST_SETUP;
`ifdef QSPI_CMD_TX_CRC_EN
                    crc_s      = crc_next_s;
                    crc_sent_s = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 8'd0) begin
                    sck_s   = 1'b1;
                    cnt_s   = DIV_LD;
                    state_s = ST_HIGH;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_HIGH: begin
                if (cnt_r != 8'd0) begin
                    cnt_s = cnt_r - 8'd1;
                end else if (nib_hi_r) begin
                    sck_s    = 1'b0;
                    io_s     = byte_r[3:0];
                    nib_hi_s = 1'b0;
                    cnt_s    = DIV_LD;
                    state_s  = ST_LOW;
                end else if (!last_r) begin
                    sck_s   = 1'b0;
                    state_s = ST_NEXT;
`ifdef QSPI_CMD_TX_CRC_EN
                end else if (!crc_sent_r) begin
                    // Trailer byte: reuse the byte buffer for the CRC.
                    sck_s      = 1'b0;
                    byte_s     = crc_r;
                    io_s       = crc_r[7:4];
                    nib_hi_s   = 1'b1;
                    crc_sent_s = 1'b1;
                    cnt_s      = DIV_LD;
                    state_s    = ST_LOW;
`endif
                end else begin
                    sck_s   = 1'b0;
                    cnt_s   = HOLD_LD;
                    state_s = ST_HOLD;
                end
            end
            ST_LOW: begin
                if (cnt_r == 8'd0) begin
                    sck_s   = 1'b1;
                    cnt_s   = DIV_LD;
                    state_s = ST_HIGH;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_NEXT: begin
                if (s_valid) begin
                    byte_s   = s_data;
                    last_s   = s_last;
                    nib_hi_s = 1'b1;
                    io_s     = s_data[7:4];
                    cnt_s    = DIV_LD;
                    state_s  = ST_LOW;
`ifdef QSPI_CMD_TX_CRC_EN
                    crc_s = crc_next_s;
`endif
                end else begin
                    state_s = ST_NEXT;
                end
            end
            ST_HOLD: begin
                if (cnt_r == 8'd0) begin
                    cs_n_s  = 1'b1;
                    oe_s    = 1'b0;
                    io_s    = 4'd0;
                    done_s  = 1'b1;
                    cnt_s   = GAP_LD;
                    state_s = ST_GAP;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_r == 8'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                sck_s   = 1'b0;
                cs_n_s  = 1'b1;
                oe_s    = 1'b0;
                io_s    = 4'd0;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, phase counter, byte buffer and registered pin drivers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            byte_r   <= 8'd0;
            last_r   <= 1'b0;
            nib_hi_r <= 1'b0;
            sck_r    <= 1'b0;
            cs_n_r   <= 1'b1;
            io_r     <= 4'd0;
            oe_r     <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            byte_r   <= byte_s;
            last_r   <= last_s;
            nib_hi_r <= nib_hi_s;
            sck_r    <= sck_s;
            cs_n_r   <= cs_n_s;
            io_r     <= io_s;
            oe_r     <= oe_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

`ifdef QSPI_CMD_TX_CRC_EN
    // Running CRC of the current frame and trailer-sent flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_r      <= CRC8_INIT;
            crc_sent_r <= 1'b0;
        end else begin
            crc_r      <= crc_s;
            crc_sent_r <= crc_sent_s;
        end
    end
`endif

endmodule

// File: tb/tb_qspi_cmd_tx.sv
// tb_qspi_cmd_tx: scoreboard bench for qspi_cmd_tx. Expected nibbles are
// queued when a byte is handed over and popped at each sck rise; framing
// and timing are measured at the falling clock edge.
`timescale 1ns/1ps
module tb_qspi_cmd_tx;

`ifdef QSPI_CMD_TX_CRC_EN
    localparam bit CRC_ON    = 1'b1;
    localparam int CRC_EXTRA = 8;
`else
    localparam bit CRC_ON    = 1'b0;
    localparam int CRC_EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] s_data, f_s_data;
    logic       s_valid, s_last, s_ready, f_s_valid, f_s_last, f_s_ready;
    logic       sck, cs_n, oe, busy, frame_done;
    logic       f_sck, f_cs_n, f_oe, f_busy, f_frame_done;
    logic [3:0] io, f_io;

    qspi_cmd_tx dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .sck(sck), .CS_n(cs_n), .spi_io_o(io), .spi_io_oe(oe),
        .busy(busy), .frame_done(frame_done)
    );

    qspi_cmd_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut_f (
        .clk(clk), .rst(rst), .s_data(f_s_data), .s_valid(f_s_valid), .s_last(f_s_last),
        .s_ready(f_s_ready), .sck(f_sck), .CS_n(f_cs_n), .spi_io_o(f_io), .spi_io_oe(f_oe),
        .busy(f_busy), .frame_done(f_frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] tb_crc8(input logic [7:0] d, input logic [7:0] c_in);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Scoreboards and measurements
    logic [3:0] exp_q[$];
    logic [3:0] fexp_q[$];
    int rise_cyc[$];
    int frise[$];
    int cyc = 0, cs_len = 0, last_cs_len = 0, fd_cnt = 0, cs_rise_cyc = 0, rdy_rise_cyc = 0;
    int idle_toggle = 0, fcs_hi = 0, fgap = 0, f_frames = 0;
    logic [7:0] seen_byte = 8'd0;
    logic sck_q = 1'b0, cs_q = 1'b1, rdy_q = 1'b0, fsck_q = 1'b0, fcs_q = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sck && !sck_q) begin
            rise_cyc.push_back(cyc);
            seen_byte = {seen_byte[3:0], io};
            check_eq("cs_low_at_rise", int'(cs_n), 0);
            check_eq("oe_at_rise", int'(oe), 1);
            check_eq("nibble_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("nibble", int'(io), int'(exp_q.pop_front()));
        end
        if (sck != sck_q && cs_n && cs_q) idle_toggle++;
        if (cs_n && !cs_q) begin
            if (rst) begin
                last_cs_len = cs_len;
                cs_rise_cyc = cyc;
                check_eq("frame_done_on_cs_rise", int'(frame_done), 1);
            end
            cs_len = 0;
        end
        if (!cs_n) cs_len++;
        if (frame_done) fd_cnt++;
        if (s_ready && !rdy_q) rdy_rise_cyc = cyc;
        sck_q = sck; cs_q = cs_n; rdy_q = s_ready;

        if (f_sck && !fsck_q) begin
            frise.push_back(cyc);
            check_eq("f_nibble_expected", int'(fexp_q.size() > 0), 1);
            if (fexp_q.size() > 0) check_eq("f_nibble", int'(f_io), int'(fexp_q.pop_front()));
        end
        if (f_cs_n && !fcs_q && rst) f_frames++;
        if (!f_cs_n && fcs_q && f_frames > 0) fgap = fcs_hi;
        fcs_hi = f_cs_n ? fcs_hi + 1 : 0;
        fsck_q = f_sck; fcs_q = f_cs_n;
    end

    logic [7:0] crc_m = 8'd0, fcrc_m = 8'd0;
    bit in_frame = 1'b0, f_in_frame = 1'b0;

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        s_data = d; s_last = last; s_valid = 1'b1;
        while (!s_ready && t < 1000) begin @(negedge clk); t++; end
        check_eq("handshake_in_time", int'(t < 1000), 1);
        if (!in_frame) crc_m = 8'h00;
        crc_m = tb_crc8(d, crc_m);
        in_frame = !last;
        exp_q.push_back(d[7:4]);
        exp_q.push_back(d[3:0]);
        if (CRC_ON && last) begin
            exp_q.push_back(crc_m[7:4]);
            exp_q.push_back(crc_m[3:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic f_send(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        f_s_data = d; f_s_last = last; f_s_valid = 1'b1;
        while (!f_s_ready && t < 1000) begin @(negedge clk); t++; end
        check_eq("f_handshake_in_time", int'(t < 1000), 1);
        if (!f_in_frame) fcrc_m = 8'h00;
        fcrc_m = tb_crc8(d, fcrc_m);
        f_in_frame = !last;
        fexp_q.push_back(d[7:4]);
        fexp_q.push_back(d[3:0]);
        if (CRC_ON && last) begin
            fexp_q.push_back(fcrc_m[7:4]);
            fexp_q.push_back(fcrc_m[3:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (!(s_ready && !busy && !f_busy) && t < 2000) begin @(negedge clk); t++; end
        check_eq(tag, int'(t < 2000), 1);
        @(negedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, viol;
        rst = 1'b0;
        s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0;
        f_s_data = 8'd0; f_s_valid = 1'b0; f_s_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outputs", int'({sck, cs_n, io, oe, busy, frame_done, s_ready}), int'(10'b0_1_0000_0_0_0_0));
        check_eq("f_reset_outputs", int'({f_sck, f_cs_n, f_io, f_oe, f_busy, f_frame_done, f_s_ready}), int'(10'b0_1_0000_0_0_0_0));
        @(negedge clk); #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // One-byte frame 0xA5
        fd0 = fd_cnt;
        send_byte(8'hA5, 1'b1); s_valid = 1'b0;
        wait_idle("t1_idle");
        check_eq("t1_cs_len", last_cs_len, 10 + CRC_EXTRA);
        check_eq("t1_fd_once", fd_cnt - fd0, 1);
        check_eq("t1_ready_after_cs", rdy_rise_cyc - cs_rise_cyc, 4);
        check_eq("t1_drained", exp_q.size(), 0);

        // Streaming 0x01,0x02,0x03
        rise_cyc.delete();
        fd0 = fd_cnt;
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b1); s_valid = 1'b0;
        wait_idle("t2_idle");
        check_eq("t2_rises", rise_cyc.size(), CRC_ON ? 8 : 6);
        check_eq("t2_period_a", rise_cyc[2] - rise_cyc[0], 9);
        check_eq("t2_period_b", rise_cyc[4] - rise_cyc[2], 9);
        check_eq("t2_cs_len", last_cs_len, 28 + CRC_EXTRA);
        check_eq("t2_fd_once", fd_cnt - fd0, 1);
        check_eq("t2_drained", exp_q.size(), 0);

        // Stall between bytes
        send_byte(8'h11, 1'b0); s_valid = 1'b0;
        repeat (12) @(negedge clk);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (sck || cs_n || !s_ready) viol++;
        end
        check_eq("t3_stall_held", viol, 0);
        send_byte(8'h22, 1'b1); s_valid = 1'b0;
        wait_idle("t3_idle");
        check_eq("t3_drained", exp_q.size(), 0);

        // Reset mid-byte
        fd0 = fd_cnt;
        send_byte(8'h3C, 1'b1); s_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t4_async_reset", int'({cs_n, sck, oe, frame_done, busy}), int'(5'b10000));
        exp_q.delete();
        in_frame = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t4_no_frame_done", fd_cnt - fd0, 0);
        send_byte(8'h5A, 1'b1); s_valid = 1'b0;
        wait_idle("t4_idle");
        check_eq("t4_fd_after", fd_cnt - fd0, 1);
        check_eq("t4_cs_len", last_cs_len, 10 + CRC_EXTRA);
        check_eq("t4_drained", exp_q.size(), 0);

`ifdef QSPI_CMD_TX_CRC_EN
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b1); s_valid = 1'b0;
        wait_idle("crc_idle");
        check_eq("crc_trailer", int'(seen_byte), int'(8'h1B));
`endif

        // Fast instance: minimum timing, back-to-back frames
        frise.delete();
        f_send(8'h96, 1'b1); f_send(8'h69, 1'b1); f_s_valid = 1'b0;
        wait_idle("f_idle");
        check_eq("f_sck_period", frise[1] - frise[0], 2);
        check_eq("f_gap_min", int'(fgap >= 1), 1);
        check_eq("f_gap_exact", fgap, 2);
        check_eq("f_frames", f_frames, 2);
        check_eq("f_drained", fexp_q.size(), 0);

        check_eq("no_sck_while_cs_high", idle_toggle, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
